// File: rtl/sdram_arbit_pkg.sv
// Shared definitions for the SDRAM arbiter: command encodings and arbiter states.
package sdram_arbit_pkg;

  localparam int unsigned CMD_W = 4;
  localparam int unsigned BA_W  = 2;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_NOP          = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_WRITE        = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_READ         = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_LOAD_MODE    = 4'b0000;

  localparam logic [BA_W-1:0]  BA_IDLE          = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_A_REF = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sdram_cmd_mux.sv
// State-driven command/bank/address mux onto the SDRAM pins plus the DQ tristate.
module sdram_cmd_mux
  import sdram_arbit_pkg::*;
#(
  parameter int unsigned DQ_W   = 16,
  parameter int unsigned ADDR_W = 13
) (
  input  arb_state_e         state,
  input  logic [CMD_W-1:0]   init_cmd,
  input  logic [BA_W-1:0]    init_ba,
  input  logic [ADDR_W-1:0]  init_addr,
  input  logic [CMD_W-1:0]   a_ref_cmd,
  input  logic [BA_W-1:0]    a_ref_ba,
  input  logic [ADDR_W-1:0]  a_ref_addr,
  input  logic [CMD_W-1:0]   wr_cmd,
  input  logic [BA_W-1:0]    wr_ba,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [CMD_W-1:0]   rd_cmd,
  input  logic [BA_W-1:0]    rd_ba,
  input  logic [ADDR_W-1:0]  rd_addr,
  input  logic               wr_sdram_en,
  input  logic [DQ_W-1:0]    wr_sdram_data,
  output logic               sdram_cs_n,
  output logic               sdram_ras_n,
  output logic               sdram_cas_n,
  output logic               sdram_we_n,
  output logic [BA_W-1:0]    sdram_ba,
  output logic [ADDR_W-1:0]  sdram_addr,
  inout  wire  [DQ_W-1:0]    sdram_dq
);

  logic [CMD_W-1:0] cmd_c;

  // The current bus owner drives the pins; ARBIT idles the bus with a NOP.
  always_comb begin
    cmd_c      = CMD_NOP;
    sdram_ba   = BA_IDLE;
    sdram_addr = {ADDR_W{1'b1}};
    unique case (state)
      ST_INIT: begin
        cmd_c      = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      ST_A_REF: begin
        cmd_c      = a_ref_cmd;
        sdram_ba   = a_ref_ba;
        sdram_addr = a_ref_addr;
      end
      ST_WRITE: begin
        cmd_c      = wr_cmd;
        sdram_ba   = wr_ba;
        sdram_addr = wr_addr;
      end
      ST_READ: begin
        cmd_c      = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: begin
        cmd_c      = CMD_NOP;
        sdram_ba   = BA_IDLE;
        sdram_addr = {ADDR_W{1'b1}};
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_c;

  assign sdram_dq = wr_sdram_en ? wr_sdram_data : {DQ_W{1'bz}};

endmodule

// File: rtl/sdram_arbit.sv
// Fixed-priority owner arbiter for the SDRAM command bus (refresh > write > read).
module sdram_arbit
  import sdram_arbit_pkg::*;
#(
  parameter int unsigned DQ_W   = 16,
  parameter int unsigned ADDR_W = 13
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               init_end,
  input  logic [CMD_W-1:0]   init_cmd,
  input  logic [BA_W-1:0]    init_ba,
  input  logic [ADDR_W-1:0]  init_addr,
  input  logic               a_ref_req,
  input  logic               a_ref_end,
  input  logic [CMD_W-1:0]   a_ref_cmd,
  input  logic [BA_W-1:0]    a_ref_ba,
  input  logic [ADDR_W-1:0]  a_ref_addr,
  input  logic               wr_req,
  input  logic               wr_end,
  input  logic [CMD_W-1:0]   wr_cmd,
  input  logic [BA_W-1:0]    wr_ba,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic               wr_sdram_en,
  input  logic [DQ_W-1:0]    wr_sdram_data,
  input  logic               rd_req,
  input  logic               rd_end,
  input  logic [CMD_W-1:0]   rd_cmd,
  input  logic [BA_W-1:0]    rd_ba,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               a_ref_en,
  output logic               wr_en,
  output logic               rd_en,
  output logic               sdram_cke,
  output logic               sdram_cs_n,
  output logic               sdram_ras_n,
  output logic               sdram_cas_n,
  output logic               sdram_we_n,
  output logic [BA_W-1:0]    sdram_ba,
  output logic [ADDR_W-1:0]  sdram_addr,
  inout  wire  [DQ_W-1:0]    sdram_dq
);

  arb_state_e state_q, state_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_INIT;
    else            state_q <= state_d;
  end

  // Owners hold the bus until their own end pulse; other end pulses are ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: begin
        if (init_end) state_d = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (a_ref_req)   state_d = ST_A_REF;
        else if (wr_req) state_d = ST_WRITE;
        else if (rd_req) state_d = ST_READ;
      end
      ST_A_REF: begin
        if (a_ref_end) state_d = ST_ARBIT;
      end
      ST_WRITE: begin
        if (wr_end) state_d = ST_ARBIT;
      end
      ST_READ: begin
        if (rd_end) state_d = ST_ARBIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign a_ref_en  = (state_q == ST_A_REF);
  assign wr_en     = (state_q == ST_WRITE);
  assign rd_en     = (state_q == ST_READ);
  assign sdram_cke = 1'b1;

  sdram_cmd_mux #(
    .DQ_W   (DQ_W),
    .ADDR_W (ADDR_W)
  ) u_cmd_mux (
    .state         (state_q),
    .init_cmd      (init_cmd),
    .init_ba       (init_ba),
    .init_addr     (init_addr),
    .a_ref_cmd     (a_ref_cmd),
    .a_ref_ba      (a_ref_ba),
    .a_ref_addr    (a_ref_addr),
    .wr_cmd        (wr_cmd),
    .wr_ba         (wr_ba),
    .wr_addr       (wr_addr),
    .rd_cmd        (rd_cmd),
    .rd_ba         (rd_ba),
    .rd_addr       (rd_addr),
    .wr_sdram_en   (wr_sdram_en),
    .wr_sdram_data (wr_sdram_data),
    .sdram_cs_n    (sdram_cs_n),
    .sdram_ras_n   (sdram_ras_n),
    .sdram_cas_n   (sdram_cas_n),
    .sdram_we_n    (sdram_we_n),
    .sdram_ba      (sdram_ba),
    .sdram_addr    (sdram_addr),
    .sdram_dq      (sdram_dq)
  );

endmodule
